// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states and
// the default datapath width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for every funct code this unit owns (and may therefore stall).
    function automatic logic fn_handled(input logic [5:0] fn);
        case (fn)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: fn_handled = 1'b1;
            default:                            fn_handled = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the shift-add multiplier or restoring divider.
// acc is the product high half / partial remainder, quo the multiplier / quotient.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] opd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    assign sum_s     = {1'b0, acc} + (quo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
    assign shifted_s = {acc, quo[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, opd};

    // Select the multiply or divide step; a negative trial difference restores.
    always_comb begin
        acc_next = acc;
        quo_next = quo;
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                acc_next = diff_s[WIDTH-1:0];
                quo_next = {quo[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted_s[WIDTH-1:0];
                quo_next = {quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = sum_s[WIDTH:1];
            quo_next = {sum_s[0], quo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Multi-cycle mult/div sequencer beside EX: owns HI/LO, services mf/mt moves
// and stalls the pipeline while an iterative operation is in flight.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       funcode,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_r, quo_r, opd_r;
    logic [WIDTH-1:0]   acc_next_s, quo_next_s;
    logic               is_div_r, neg_res_r, neg_rem_r, div0_r;
    logic               start_s, is_div_s, signed_s, mt_hi_s, mt_lo_s;
    logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    assign stall = op_valid & busy & fn_handled(funcode);

    // Decode instructions that may be accepted this cycle (idle only).
    always_comb begin
        start_s  = 1'b0;
        is_div_s = 1'b0;
        signed_s = 1'b0;
        mt_hi_s  = 1'b0;
        mt_lo_s  = 1'b0;
        if (op_valid && (state_r == ST_IDLE)) begin
            case (funcode)
                FN_MULT:  begin start_s = 1'b1; signed_s = 1'b1; end
                FN_MULTU: begin start_s = 1'b1; end
                FN_DIV:   begin start_s = 1'b1; is_div_s = 1'b1; signed_s = 1'b1; end
                FN_DIVU:  begin start_s = 1'b1; is_div_s = 1'b1; end
                FN_MTHI:  begin mt_hi_s = 1'b1; end
                FN_MTLO:  begin mt_lo_s = 1'b1; end
                default:  begin start_s = 1'b0; end
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    assign rs_mag_s = (signed_s && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag_s = (signed_s && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Next-state logic for IDLE -> RUN -> FIX -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_RUN;
                else         state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) state_s = ST_FIX;
                else                   state_s = ST_RUN;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != ST_IDLE);
            done    <= (state_r == ST_FIX);
        end
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .quo      (quo_r),
        .opd      (opd_r),
        .acc_next (acc_next_s),
        .quo_next (quo_next_s)
    );

    // Operand latch at start and one datapath step per RUN cycle.
    // Divide-by-zero keeps the raw dividend so it falls out unchanged as HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            quo_r     <= '0;
            opd_r     <= '0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            is_div_r  <= is_div_s;
            neg_res_r <= signed_s & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_r <= signed_s & rs_val[WIDTH-1];
            div0_r    <= is_div_s & (rt_val == '0);
            if (is_div_s) begin
                quo_r <= (rt_val == '0) ? rs_val : rs_mag_s;
                opd_r <= rt_mag_s;
            end else begin
                quo_r <= rt_mag_s;
                opd_r <= rs_mag_s;
            end
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r + CNT_W'(1);
            acc_r <= acc_next_s;
            quo_r <= quo_next_s;
        end
    end

    assign prod_s    = neg_res_r ? -{acc_r, quo_r} : {acc_r, quo_r};
    assign quo_fix_s = (neg_res_r && !div0_r) ? -quo_r : quo_r;
    assign rem_fix_s = (neg_rem_r && !div0_r) ? -acc_r : acc_r;

    // HI/LO: result write in FIX, direct moves only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state_r == ST_FIX) begin
            if (is_div_r) begin
                hi <= rem_fix_s;
                lo <= quo_fix_s;
            end else begin
                {hi, lo} <= prod_s;
            end
        end else begin
            if (mt_hi_s) hi <= rs_val;
            if (mt_lo_s) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed self-checking bench for muldiv_controller with hand-computed results.
module tb_muldiv_controller;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  funcode = 6'h00;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_controller #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .funcode(funcode),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Issue one op at the next edge (cycle 0) and observe cycles 1..36.
    task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int done_at, output int pulses,
                         output logic [31:0] hi_v, output logic [31:0] lo_v);
        busy_n = 0; done_at = -1; pulses = 0; hi_v = 32'h0; lo_v = 32'h0;
        @(negedge clk);
        op_valid = 1'b1; funcode = fn; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = k; hi_v = hi; lo_v = lo;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        op_valid = 1'b1; funcode = FN_MFHI;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        op_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int bn, da, pn;
        logic [31:0] hv, lv;
        do_op(fn, a, b, bn, da, pn, hv, lv);
        total++; if (bn !== 33) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=33", name, bn); end
        total++; if (da !== 34) begin bad++; $display("FAIL %s_done_cycle got=%0d want=34", name, da); end
        total++; if (pn !== 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", name, pn); end
        total++; if (hv !== eh) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, hv, eh); end
        total++; if (lv !== el) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, lv, el); end
    endtask

    task automatic test_mult;
        check_op("mult_7xm3", FN_MULT, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        check_op("mult_m1xm1", FN_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    endtask

    task automatic test_div;
        check_op("div_m7d2", FN_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("divu_by0", FN_DIVU, 32'd100, 32'h0, 32'h00000064, 32'hFFFFFFFF);
        check_op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        check_op("div_m5by0", FN_DIV, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        check_op("divu_big", FN_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
    endtask

    task automatic test_mf_stall_mt;
        @(negedge clk);
        op_valid = 1'b1; funcode = FN_MTHI; rs_val = 32'h1234;
        @(posedge clk); #1;
        op_valid = 1'b0;
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h want=00001234", hi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", busy); end
        @(negedge clk);
        op_valid = 1'b1; funcode = FN_MTLO; rs_val = 32'hABCD;
        @(posedge clk); #1;
        op_valid = 1'b0; funcode = 6'h20;
        total++; if (lo !== 32'hABCD) begin bad++; $display("FAIL mtlo_lo got=%h want=0000abcd", lo); end
        // mult 0x10000 * 0x30000 = 0x3_0000_0000, mfhi held from cycle 5
        @(negedge clk);
        op_valid = 1'b1; funcode = FN_MULT; rs_val = 32'h10000; rt_val = 32'h30000;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (c == 5) begin op_valid = 1'b1; funcode = FN_MFHI; end
            @(negedge clk);
            if (c >= 5 && c <= 33) begin
                total++; if (stall !== 1'b1) begin bad++; $display("FAIL mfhi_stall c=%0d got=%b want=1", c, stall); end
            end else if (c == 34) begin
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL mfhi_release got=%b want=0", stall); end
                total++; if (hi !== 32'h3) begin bad++; $display("FAIL mfhi_value got=%h want=00000003", hi); end
                total++; if (lo !== 32'h0) begin bad++; $display("FAIL mflo_value got=%h want=00000000", lo); end
            end else if (c < 5) begin
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL pre_mfhi_stall c=%0d got=%b want=0", c, stall); end
            end else begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL mf_no_restart got=%b want=0", busy); end
            end
            @(posedge clk); #1;
            if (c == 34) op_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        @(negedge clk);
        op_valid = 1'b1; funcode = FN_MULT; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1;
        for (int c = 1; c <= 72; c++) begin
            if (c == 10) begin
                op_valid = 1'b1; funcode = 6'h20;
            end else if (c <= 34) begin
                op_valid = 1'b1; funcode = FN_MULT; rs_val = 32'd4; rt_val = 32'd5;
            end else begin
                op_valid = 1'b0; funcode = 6'h00;
            end
            @(negedge clk);
            if (done) pulses++;
            if (c == 10) begin
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_other_fn_stall got=%b want=0", stall); end
            end
            if (c == 20) begin
                total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_held_stall got=%b want=1", stall); end
            end
            if (c == 34) begin
                total++; if (done !== 1'b1 || lo !== 32'd6) begin bad++; $display("FAIL b2b_first done=%b lo=%h want done=1 lo=00000006", done, lo); end
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_accept_stall got=%b want=0", stall); end
            end
            if (c == 35) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_start got=%b want=1", busy); end
            end
            if (c == 68) begin
                total++; if (done !== 1'b1 || lo !== 32'd20) begin bad++; $display("FAIL b2b_second done=%b lo=%h want done=1 lo=00000014", done, lo); end
            end
            @(posedge clk); #1;
        end
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
    endtask

    task automatic test_async_reset;
        int pulses = 0;
        @(negedge clk);
        op_valid = 1'b1; funcode = FN_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL arst_hilo hi=%h lo=%h want 0/0", hi, lo); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL arst_no_done got=%0d want=0", pulses); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL arst_no_partial lo=%h want=0", lo); end
        check_op("post_rst_mult", FN_MULT, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mf_stall_mt();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
Sequences the multi-cycle multiply/divide resource of the pipelined MIPS core and owns the HI/LO registers.
- Sits beside the EX stage; alu_controller decodes funcodes 0x10-0x13, 0x18-0x1B to it.
- Runs an iterative 32-step shift-add multiplier and a restoring divider for mult/multu/div/divu.
- Services mfhi/mflo/mthi/mtlo, and stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
op_valid  input  1  EX stage holds a valid R-type instruction this cycle
funcode  input  6  instruction funct field
rs_val  input  WIDTH  rs operand (dividend / multiplicand / mthi/mtlo source)
rt_val  input  WIDTH  rt operand (divisor / multiplier)
stall  output  1  combinational; hold IF/ID/EX this cycle
busy  output  1  registered; iterative operation in progress
done  output  1  registered; one-cycle pulse when HI/LO take a mult/div result
hi  output  WIDTH  HI register (read by mfhi mux)
lo  output  WIDTH  LO register (read by mflo mux)

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal accumulators 0. Reset mid-operation aborts it; no partial result reaches HI/LO.
- Funcodes handled: 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu. Other funcodes are ignored: no stall, no state change.
- stall = op_valid & busy & (funcode is any handled code). It is never asserted in IDLE.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, op_valid with mult/multu/div/divu and not stalled:
  - Latch the operands. For signed ops, latch magnitudes and record the sign flags.
  - Clear the counter. Next state RUN, busy=1 from the next cycle.
- IDLE, mthi/mtlo: hi (resp. lo) <= rs_val at the clock edge; single cycle; busy stays 0.
- IDLE, mfhi/mflo: no state change; the pipeline reads the hi/lo ports directly.
- RUN: one shift-add (mul) or shift-subtract-restore (div) step per cycle for exactly WIDTH cycles. After the step at counter=WIDTH-1, next state is FIX.
- FIX (1 cycle): apply sign correction, then write HI/LO at the FIX clock edge. Next state IDLE, busy=0, done=1 for exactly one cycle.
  - mult: 64-bit product negated if the operand signs differ.
  - div: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Result mapping: mult gives {HI,LO} = product. div gives LO = quotient, HI = remainder.
- Latency: start edge at cycle 0; busy high cycles 1..WIDTH+1; HI/LO updated and done high in cycle WIDTH+2 (34 for WIDTH=32).
- A stalled instruction stays on op_valid/funcode. In the cycle busy falls it is accepted (mf reads the new HI/LO, mt writes, or a new mult/div starts).
- Arithmetic boundaries:
  - Divide by zero (rt_val=0, div or divu): same latency. LO=all ones, HI=rs_val unmodified; sign fix is bypassed.
  - Signed div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (magnitude path wraps naturally).
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- Simultaneous events: rst dominates everything. A start is never accepted while busy, so no overlap is possible.

Decomposition:
- Shared package holds:
  - funcode localparams FN_MFHI..FN_DIVU, shared with alu_controller.
  - State encoding IDLE/RUN/FIX.
  - WIDTH default.
- One natural sub-module: muldiv_iter_core. It holds the combinational single-step datapath (one add/shift step or one subtract/restore step) for the accumulator, remainder and quotient registers. The FSM, counter, sign flags and HI/LO registers stay in muldiv_controller.

Test Plan:
- mult rs=7, rt=0xFFFFFFFD, start at cycle 0 -> busy in cycles 1-33; at cycle 34 done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 34 cycles; then mult of the same operands -> HI=0, LO=1.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu rs=100, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- mfhi presented at cycle 5 of a mult -> stall=1 in cycles 5-33, 0 in cycle 34; hi then shows the new product. mthi 0x1234 while idle -> hi=0x1234 next cycle, busy stays 0.
- Back-to-back: a second mult presented while busy is stalled and then starts in cycle 34 with done pulsing once per op. A non-muldiv funcode (0x20) while busy -> stall=0.
- rst asserted asynchronously at cycle 10 of a div -> busy=0, hi=lo=0 immediately, no done pulse; a new mult after release completes normally.
